rf_wb_arbiter: RTL and testbench

//  Write-side front end of the 32x32 register file. Merges single-cycle ALU results with
//  out-of-order-timed load (LSU) results into the register file's one write port
//  (RegWrite/rd/rd_value), buffering LSU results in a small FIFO.

---
 rtl/rf_wb_arbiter_if.sv | 37 +++
 rtl/rf_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Register-file write-side bundle: ALU/LSU result sources, load-issue scoreboard updates,
// decode busy queries and the registered write port toward the register file.
interface rf_wb_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      rs1_i;
    logic [4:0]      rs2_i;
    logic            rs1_busy_o;
    logic            rs2_busy_o;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            err_o;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd, rs1_i, rs2_i,
        input  lsu_ready, rs1_busy_o, rs2_busy_o, rf_we, rf_rd, rf_wdata, err_o
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd, rs1_i, rs2_i,
        output lsu_ready, rs1_busy_o, rs2_busy_o, rf_we, rf_rd, rf_wdata, err_o
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Merges ALU results (priority) and FIFO-buffered LSU results onto the single register-file
// write port, and tracks pending load destinations for decode RAW stalls.
module rf_wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DepthC  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LastPtr = PW'(FIFO_DEPTH - 1);

    logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pending_q, pending_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            err_q, err_d;

    logic            lsu_ready;
    logic            alu_sel, push, pop;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic            iss_dup, push_orphan;

    // Ready comes from the registered count only, so a full FIFO refuses even if it pops now.
    assign lsu_ready = !rst && (count_q < DepthC);
    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        alu_sel = bus.alu_valid && (bus.alu_rd != 5'd0);
        push    = bus.lsu_valid && lsu_ready;
        pop     = !alu_sel && (count_q != '0);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        // Clear on pop first so a same-cycle re-issue of that rd leaves it pending.
        pending_d = pending_q;
        if (pop) begin
            pending_d[head_rd] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
            pending_d[bus.iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_sel) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = bus.alu_rd;
            rf_wdata_d = bus.alu_data;
        end else if (pop) begin
            rf_we_d    = (head_rd != 5'd0);
            rf_rd_d    = head_rd;
            rf_wdata_d = head_data;
        end

        iss_dup     = bus.iss_valid && (bus.iss_rd != 5'd0) && pending_q[bus.iss_rd]
                      && !(pop && (head_rd == bus.iss_rd));
        push_orphan = push && (bus.lsu_rd != 5'd0) && !pending_q[bus.lsu_rd];
        err_d       = err_q || iss_dup || push_orphan;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    // Entry storage needs no reset: occupancy is owned by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.lsu_rd;
            fifo_data_q[wr_ptr_q] <= bus.lsu_data;
        end
    end

    // The register file has no write->read bypass, so the in-flight write also reports busy.
    assign bus.rs1_busy_o = (bus.rs1_i != 5'd0)
                            && (pending_q[bus.rs1_i] || (rf_we_q && (rf_rd_q == bus.rs1_i)));
    assign bus.rs2_busy_o = (bus.rs2_i != 5'd0)
                            && (pending_q[bus.rs2_i] || (rf_we_q && (rf_rd_q == bus.rs2_i)));

    assign bus.lsu_ready = lsu_ready;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.err_o     = err_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand-written corner sequences, and random
// traffic compared each cycle against a queue-based reference model.
module tb_rf_wb_arbiter;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.XLEN(XLEN)) bus ();

    rf_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        lsu_valid;
        logic [4:0]  lsu_rd;
        logic [31:0] lsu_data;
        logic        iss_valid;
        logic [4:0]  iss_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        ready;
        logic        b1;
        logic        b2;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO as a queue, scoreboard as a bit per register.
    ent_t      mq[$];
    bit [31:0] m_pend;
    bit        m_we;
    bit [4:0]  m_rd;
    bit [31:0] m_wdata;
    bit        m_err;

    function automatic bit m_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit m_busy(input bit [4:0] rs);
        return (rs != 0) && (m_pend[rs] || (m_we && m_rd == rs));
    endfunction

    task automatic m_reset();
        mq.delete();
        m_pend  = '0;
        m_we    = 0;
        m_rd    = '0;
        m_wdata = '0;
        m_err   = 0;
    endtask

    task automatic m_step(input stim_t s);
        bit   alu_sel, push, pop;
        ent_t head;
        alu_sel = s.alu_valid && s.alu_rd != 0;
        push    = s.lsu_valid && m_ready();
        pop     = !alu_sel && mq.size() != 0;
        head    = pop ? mq[0] : '0;
        if (s.iss_valid && s.iss_rd != 0 && m_pend[s.iss_rd] && !(pop && head.rd == s.iss_rd))
            m_err = 1;
        if (push && s.lsu_rd != 0 && !m_pend[s.lsu_rd]) m_err = 1;
        if (pop) m_pend[head.rd] = 0;
        if (s.iss_valid && s.iss_rd != 0) m_pend[s.iss_rd] = 1;
        if (alu_sel) begin
            m_we = 1; m_rd = s.alu_rd; m_wdata = s.alu_data;
        end else if (pop) begin
            m_we = (head.rd != 0); m_rd = head.rd; m_wdata = head.data;
        end else begin
            m_we = 0;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({s.lsu_rd, s.lsu_data});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("model_ready", 32'(bus.lsu_ready), 32'(m_ready()));
        chk("model_busy1", 32'(bus.rs1_busy_o), 32'(m_busy(bus.rs1_i)));
        chk("model_busy2", 32'(bus.rs2_busy_o), 32'(m_busy(bus.rs2_i)));
        chk("model_we", 32'(bus.rf_we), 32'(m_we));
        chk("model_err", 32'(bus.err_o), 32'(m_err));
        if (m_we) begin
            chk("model_rd", 32'(bus.rf_rd), 32'(m_rd));
            chk("model_wdata", bus.rf_wdata, m_wdata);
        end
    endtask

    task automatic drive(input stim_t s);
        bus.alu_valid = s.alu_valid;
        bus.alu_rd    = s.alu_rd;
        bus.alu_data  = s.alu_data;
        bus.lsu_valid = s.lsu_valid;
        bus.lsu_rd    = s.lsu_rd;
        bus.lsu_data  = s.lsu_data;
        bus.iss_valid = s.iss_valid;
        bus.iss_rd    = s.iss_rd;
        bus.rs1_i     = s.rs1;
        bus.rs2_i     = s.rs2;
    endtask

    // One cycle: apply at edge+1, compare mid-cycle, advance model, return at next edge+1.
    task automatic tick(input stim_t s);
        drive(s);
        #3;
        chk_model();
        m_step(s);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive('0);
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    function automatic stim_t idle(input logic [4:0] rs1, input logic [4:0] rs2);
        stim_t s = '0;
        s.rs1 = rs1;
        s.rs2 = rs2;
        return s;
    endfunction

    vec_t vecs[$];

    task automatic add(input stim_t s, input logic we, input logic [4:0] rd,
                       input logic [31:0] wdata, input logic ready, input logic b1,
                       input logic b2);
        vecs.push_back('{s, we, rd, wdata, ready, b1, b2, 1'b0});
    endtask

    initial begin
        stim_t    s;
        bit [4:0] outq[$];
        bit [4:0] r;
        bit       accepted;

        // Expected outputs per row are those visible during that row's cycle.
        s = idle(5, 7);  s.iss_valid = 1; s.iss_rd = 7;            add(s, 0, 0, 0, 1, 0, 0);
        s = idle(5, 7);  s.alu_valid = 1; s.alu_rd = 5; s.alu_data = 32'hDEADBEEF;
                                                                   add(s, 0, 0, 0, 1, 0, 1);
        s = idle(5, 7);  s.alu_valid = 1; s.alu_rd = 3; s.alu_data = 32'h33;
        s.lsu_valid = 1; s.lsu_rd = 7; s.lsu_data = 32'h1234;
                                                  add(s, 1, 5, 32'hDEADBEEF, 1, 1, 1);
        s = idle(5, 7);                           add(s, 1, 3, 32'h33, 1, 0, 1);
        s = idle(3, 7);                           add(s, 1, 7, 32'h1234, 1, 0, 1);
        s = idle(0, 7);                           add(s, 0, 0, 0, 1, 0, 0);
        s = idle(10, 0); s.iss_valid = 1; s.iss_rd = 10;           add(s, 0, 0, 0, 1, 0, 0);
        s = idle(10, 0); s.iss_valid = 1; s.iss_rd = 11;           add(s, 0, 0, 0, 1, 1, 0);
        s = idle(10, 0); s.alu_valid = 1; s.alu_rd = 1; s.alu_data = 32'h100;
        s.lsu_valid = 1; s.lsu_rd = 10; s.lsu_data = 32'hA0;       add(s, 0, 0, 0, 1, 1, 0);
        s = idle(11, 0); s.alu_valid = 1; s.alu_rd = 2; s.alu_data = 32'h200;
        s.lsu_valid = 1; s.lsu_rd = 11; s.lsu_data = 32'hB0;       add(s, 1, 1, 32'h100, 1, 1, 0);
        s = idle(11, 0); s.alu_valid = 1; s.alu_rd = 3; s.alu_data = 32'h300;
        s.lsu_valid = 1; s.lsu_rd = 0; s.lsu_data = 32'h77;        add(s, 1, 2, 32'h200, 0, 1, 0);
        s = idle(10, 0); s.alu_valid = 1; s.alu_rd = 0; s.alu_data = 32'hFFFF;
                                                                   add(s, 1, 3, 32'h300, 0, 1, 0);
        s = idle(10, 0);                                           add(s, 1, 10, 32'hA0, 1, 1, 0);
        s = idle(10, 11);                                          add(s, 1, 11, 32'hB0, 1, 0, 1);
        s = idle(0, 11); s.lsu_valid = 1; s.lsu_rd = 0; s.lsu_data = 32'h55;
                                                                   add(s, 0, 0, 0, 1, 0, 0);
        s = idle(0, 0);                                            add(s, 0, 0, 0, 1, 0, 0);
        s = idle(0, 0);                                            add(s, 0, 0, 0, 1, 0, 0);

        drive('0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_we", 32'(bus.rf_we), 0);
        chk("rst_rd", 32'(bus.rf_rd), 0);
        chk("rst_wdata", bus.rf_wdata, 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_ready", 32'(bus.lsu_ready), 0);
        rst = 1'b0;
        m_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].s);
            #3;
            chk($sformatf("vec%0d_we", i), 32'(bus.rf_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_rd", i), 32'(bus.rf_rd), 32'(vecs[i].rd));
                chk($sformatf("vec%0d_wdata", i), bus.rf_wdata, vecs[i].wdata);
            end
            chk($sformatf("vec%0d_ready", i), 32'(bus.lsu_ready), 32'(vecs[i].ready));
            chk($sformatf("vec%0d_busy1", i), 32'(bus.rs1_busy_o), 32'(vecs[i].b1));
            chk($sformatf("vec%0d_busy2", i), 32'(bus.rs2_busy_o), 32'(vecs[i].b2));
            chk($sformatf("vec%0d_err", i), 32'(bus.err_o), 32'(vecs[i].err));
            chk_model();
            m_step(vecs[i].s);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset with two buffered LSU results.
        do_reset();
        s = idle(20, 21); s.iss_valid = 1; s.iss_rd = 20; tick(s);
        s = idle(20, 21); s.iss_valid = 1; s.iss_rd = 21; tick(s);
        s = idle(20, 21); s.alu_valid = 1; s.alu_rd = 1; s.alu_data = 32'h1;
        s.lsu_valid = 1; s.lsu_rd = 20; s.lsu_data = 32'h20; tick(s);
        s = idle(20, 21); s.alu_valid = 1; s.alu_rd = 2; s.alu_data = 32'h2;
        s.lsu_valid = 1; s.lsu_rd = 21; s.lsu_data = 32'h21; tick(s);
        s = idle(20, 21); s.alu_valid = 1; s.alu_rd = 3; s.alu_data = 32'h3;
        drive(s);
        #3;
        chk("full_ready", 32'(bus.lsu_ready), 0);
        chk("full_busy1", 32'(bus.rs1_busy_o), 1);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.lsu_ready), 0);
        chk("midrst_we", 32'(bus.rf_we), 0);
        chk("midrst_busy1", 32'(bus.rs1_busy_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            tick(idle(20, 21));
            chk("postrst_we", 32'(bus.rf_we), 0);
            chk("postrst_ready", 32'(bus.lsu_ready), 1);
            chk("postrst_busy1", 32'(bus.rs1_busy_o), 0);
            chk("postrst_busy2", 32'(bus.rs2_busy_o), 0);
        end

        // Duplicate issue raises a sticky error.
        do_reset();
        s = idle(9, 0); s.iss_valid = 1; s.iss_rd = 9; tick(s);
        chk("dup_err_before", 32'(bus.err_o), 0);
        tick(s);
        chk("dup_err", 32'(bus.err_o), 1);
        for (int i = 0; i < 3; i++) tick(idle(0, 0));
        chk("dup_err_sticky", 32'(bus.err_o), 1);
        do_reset();
        chk("err_cleared", 32'(bus.err_o), 0);

        // LSU result for a register that was never issued.
        s = idle(0, 0); s.lsu_valid = 1; s.lsu_rd = 4; s.lsu_data = 32'h4; tick(s);
        chk("orphan_err", 32'(bus.err_o), 1);
        do_reset();

        // Re-issue in the very cycle the old load is popped: no error, rd stays pending.
        s = idle(13, 0); s.iss_valid = 1; s.iss_rd = 13; tick(s);
        s = idle(13, 0); s.lsu_valid = 1; s.lsu_rd = 13; s.lsu_data = 32'hC13; tick(s);
        s = idle(13, 0); s.iss_valid = 1; s.iss_rd = 13; tick(s);
        chk("reiss_we", 32'(bus.rf_we), 1);
        chk("reiss_rd", 32'(bus.rf_rd), 13);
        chk("reiss_err", 32'(bus.err_o), 0);
        tick(idle(13, 0));
        chk("reiss_pending", 32'(bus.rs1_busy_o), 1);
        chk("reiss_err2", 32'(bus.err_o), 0);
        do_reset();

        // Random legal traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            s = '0;
            s.alu_valid = ($urandom_range(0, 99) < 40);
            s.alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s.alu_data  = $urandom;
            if (outq.size() > 0 && $urandom_range(0, 99) < 60) begin
                s.lsu_valid = 1; s.lsu_rd = outq[0]; s.lsu_data = $urandom;
            end else if ($urandom_range(0, 99) < 5) begin
                s.lsu_valid = 1; s.lsu_rd = 0; s.lsu_data = $urandom;
            end
            if ($urandom_range(0, 99) < 30) begin
                r = 5'($urandom_range(1, 31));
                if (!m_pend[r]) begin
                    s.iss_valid = 1; s.iss_rd = r;
                end
            end
            s.rs1 = 5'($urandom_range(0, 31));
            s.rs2 = 5'($urandom_range(0, 31));
            accepted = s.lsu_valid && m_ready();
            tick(s);
            if (accepted && s.lsu_rd != 0) void'(outq.pop_front());
            if (s.iss_valid) outq.push_back(s.iss_rd);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
